// File: rtl/acc_order_sched.sv
// acc_order_sched
// Per-accumulator commit scheduler for forked parallel loops. Each accumulator
// accepts contributions strictly in gc order (fork_gc, fork_gc+gd, ...), so
// floating-point accumulation is identical whatever the core timing is.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   fork_valid          issue_fork pulse; loads fork_gc / fork_gd on the next edge
//   fork_gc, fork_gd    first iteration stamp, signed stride
//   req_valid/stamp/data  per (core c, acc a) request, flat index c*N_ACC+a
//   req_ready           combinational grant (handshake = valid && ready)
//   commit_valid/data/core  registered commit per accumulator
//   expected_gc         next stamp each accumulator accepts
//   idle                no request asserted anywhere
//   err_dup             sticky: more than one core matched the expected stamp
//   err_stall           sticky stall watchdog flag
//
// Optional feature: define ACC_ORDER_SCHED_WATCHDOG_EN to build the per-accumulator
// stall watchdog; without it err_stall is tied to 0.
module acc_order_sched #(
  parameter int N_CORE     = 6,
  parameter int N_ACC      = 2,
  parameter int GC_WIDTH   = 16,
  parameter int GD_WIDTH   = 16,
  parameter int WDOG_LIMIT = 1024,
  localparam int CW = (N_CORE > 1) ? $clog2(N_CORE) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             fork_valid,
  input  logic [GC_WIDTH-1:0]              fork_gc,
  input  logic [GD_WIDTH-1:0]              fork_gd,
  input  logic [N_CORE*N_ACC-1:0]          req_valid,
  input  logic [N_CORE*N_ACC*GC_WIDTH-1:0] req_stamp,
  input  logic [N_CORE*N_ACC*32-1:0]       req_data,
  output logic [N_CORE*N_ACC-1:0]          req_ready,
  output logic [N_ACC-1:0]                 commit_valid,
  output logic [N_ACC*32-1:0]              commit_data,
  output logic [N_ACC*CW-1:0]              commit_core,
  output logic [N_ACC*GC_WIDTH-1:0]        expected_gc,
  output logic                             idle,
  output logic                             err_dup,
  output logic                             err_stall
);

  logic [GC_WIDTH-1:0] exp_q [N_ACC];
  logic [GD_WIDTH-1:0] gd_q;
  logic [GC_WIDTH-1:0] gd_ext;

  logic [N_CORE-1:0]   match [N_ACC];
  logic [CW-1:0]       gidx  [N_ACC];
  logic [31:0]         gdata [N_ACC];
  logic [N_ACC-1:0]    hs;
  logic [N_ACC-1:0]    dup;

  // Stride is sign-extended (or truncated) to the stamp width; the add then
  // wraps modulo 2^GC_WIDTH in both directions.
  if (GC_WIDTH > GD_WIDTH) begin : g_sext
    assign gd_ext = {{(GC_WIDTH-GD_WIDTH){gd_q[GD_WIDTH-1]}}, gd_q};
  end else begin : g_trunc
    assign gd_ext = gd_q[GC_WIDTH-1:0];
  end

  always_comb begin
    req_ready = '0;
    hs        = '0;
    dup       = '0;
    for (int a = 0; a < N_ACC; a++) begin
      match[a] = '0;
      gidx[a]  = '0;
      gdata[a] = '0;
      for (int c = 0; c < N_CORE; c++) begin
        match[a][c] = req_valid[c*N_ACC+a] &&
                      (req_stamp[(c*N_ACC+a)*GC_WIDTH +: GC_WIDTH] == exp_q[a]);
      end
      // Walk downward so the lowest matching core wins.
      for (int c = N_CORE-1; c >= 0; c--) begin
        if (match[a][c]) begin
          gidx[a]  = CW'(c);
          gdata[a] = req_data[(c*N_ACC+a)*32 +: 32];
        end
      end
      hs[a]  = (|match[a]) && !fork_valid;
      // More than one bit set: clearing the lowest set bit leaves something.
      dup[a] = (match[a] & (match[a] - 1'b1)) != '0;
      for (int c = 0; c < N_CORE; c++) begin
        req_ready[c*N_ACC+a] = hs[a] && match[a][c] && (gidx[a] == CW'(c));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < N_ACC; a++) exp_q[a] <= '0;
      gd_q         <= GD_WIDTH'(1);
      commit_valid <= '0;
      commit_data  <= '0;
      commit_core  <= '0;
      err_dup      <= 1'b0;
    end else begin
      commit_valid <= hs;
      if (|dup) err_dup <= 1'b1;
      if (fork_valid) gd_q <= fork_gd;
      for (int a = 0; a < N_ACC; a++) begin
        if (fork_valid) begin
          exp_q[a] <= fork_gc;
        end else if (hs[a]) begin
          exp_q[a] <= exp_q[a] + gd_ext;
        end
        if (hs[a]) begin
          commit_data[a*32 +: 32] <= gdata[a];
          commit_core[a*CW +: CW] <= gidx[a];
        end
      end
    end
  end

  always_comb begin
    for (int a = 0; a < N_ACC; a++) expected_gc[a*GC_WIDTH +: GC_WIDTH] = exp_q[a];
  end

  assign idle = ~|req_valid;

`ifdef ACC_ORDER_SCHED_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_LIMIT) + 1;

  logic [WW-1:0]    wd_q [N_ACC];
  logic [N_ACC-1:0] any_req;

  always_comb begin
    any_req = '0;
    for (int a = 0; a < N_ACC; a++) begin
      for (int c = 0; c < N_CORE; c++) begin
        if (req_valid[c*N_ACC+a]) any_req[a] = 1'b1;
      end
    end
  end

  // err_stall is raised on the same edge the counter reaches the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < N_ACC; a++) wd_q[a] <= '0;
      err_stall <= 1'b0;
    end else begin
      for (int a = 0; a < N_ACC; a++) begin
        if (fork_valid || hs[a]) begin
          wd_q[a] <= '0;
        end else if (any_req[a]) begin
          if (wd_q[a] != WW'(WDOG_LIMIT)) wd_q[a] <= wd_q[a] + 1'b1;
          if (wd_q[a] >= WW'(WDOG_LIMIT - 1)) err_stall <= 1'b1;
        end
      end
    end
  end
`else
  assign err_stall = 1'b0;
`endif

endmodule

// File: doc/acc_order_sched.md
Name: acc_order_sched

Overview:
- Per-accumulator commit scheduler between the N_CORE cores and the shared accumulator registers during parallel (forked) loops.
- Each core offers one accumulator contribution per assigned global counter (gc) iteration, tagged with its gc stamp.
- The block grants contributions strictly in gc order: fork_gc, fork_gc+gd, fork_gc+2*gd, ...
- Floating-point accumulation is therefore bit-identical regardless of core timing. One commit per accumulator per cycle.

Parameters:
- N_CORE, 6, number of requesting cores (core 0 = parent).
- N_ACC, 2, number of independent accumulators.
- GC_WIDTH, 16, width of gc stamps and the expected counter.
- GD_WIDTH, 16, width of the signed stride gd.
- WDOG_LIMIT, 1024, stall-watchdog threshold in cycles (used only with the optional feature).

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fork_valid  in  1  issue_fork pulse; loads gc/gd.
- fork_gc  in  GC_WIDTH  first iteration stamp.
- fork_gd  in  GD_WIDTH  signed stride.
- req_valid  in  N_CORE*N_ACC  index [c*N_ACC+a]; core c offers a contribution to accumulator a.
- req_stamp  in  N_CORE*N_ACC*GC_WIDTH  gc stamp of each request.
- req_data  in  N_CORE*N_ACC*32  contribution data.
- req_ready  out  N_CORE*N_ACC  combinational grant; handshake = valid&&ready.
- commit_valid  out  N_ACC  registered; one contribution committed to accumulator a.
- commit_data  out  N_ACC*32  data of the committed contribution.
- commit_core  out  N_ACC*$clog2(N_CORE)  index of the granted core.
- expected_gc  out  N_ACC*GC_WIDTH  next stamp each accumulator accepts.
- idle  out  1  no req_valid asserted on any input.
- err_dup  out  1  sticky: two cores presented the matching stamp in the same cycle.
- err_stall  out  1  sticky watchdog flag; tied to 0 without the optional feature.

Behaviour:
- Reset values: expected_gc = 0 (all accumulators), gd = 1, commit_valid = 0, commit_data = 0, commit_core = 0, err_dup = 0, err_stall = 0. Watchdog counters = 0.
- Match condition, per accumulator a: core c matches when req_valid[c][a] is high and req_stamp[c][a] == exp[a].
- Grant: req_ready[c][a] = 1 only for the lowest-index matching core, and only when fork_valid = 0.
- All other requests see ready = 0. They must hold valid, stamp and data stable until granted.
- On handshake (next edge):
  - exp[a] <= exp[a] + sign-extended gd, truncated to GC_WIDTH (modulo wrap, both directions).
  - commit_valid[a] <= 1; commit_data[a] and commit_core[a] are loaded.
  - Latency from handshake to commit_valid = 1 cycle.
- No handshake: commit_valid[a] <= 0. commit_data and commit_core hold their values.
- Accumulators are fully independent. Up to N_ACC commits can occur in the same cycle.
- Duplicate stamps: if more than one core matches, the lowest index is granted and err_dup is set (sticky until reset). The remaining duplicates stall until a later stamp matches.
- Fork:
  - fork_valid forces all req_ready low that cycle.
  - Next edge: exp[a] <= fork_gc for every a; gd <= fork_gd; watchdog counters cleared.
  - In-flight commit_valid from the previous cycle still presents normally.
- Protocol: every assigned gc iteration produces exactly one request per accumulator; cores send zero-valued contributions when they have nothing to add. A missing stamp stalls that accumulator forever.
- idle is combinational: NOR of all req_valid.
- Reset mid-operation: all state returns immediately to reset values; pending requests are ignored until rst_n deasserts.

Optional Feature:
- Macro: ACC_ORDER_SCHED_WATCHDOG_EN.
- Defined:
  - Each accumulator has a counter ($clog2(WDOG_LIMIT)+1 bits).
  - The counter increments each cycle in which some req_valid[*][a] is high and no handshake occurs on a. It clears on a handshake or a fork.
  - Reaching WDOG_LIMIT sets err_stall (sticky until reset). The counter saturates.
- Undefined: no counters exist; err_stall is constant 0.

Test Plan:
- Reset: hold rst_n=0, then release -> commit_valid=0, expected_gc all 0, err_dup=0, err_stall=0, idle=1 with no requests.
- Ordering, acc0: fork gc=10, gd=3; cores 2/0/1 assert stamps 16/10/13 simultaneously -> grants on three consecutive cycles to core0, core1, core2; commit_core = 0, 1, 2; final expected_gc[0]=19.
- Negative stride and wrap: fork gc=1, gd=0xFFFF; core3 stamps 1, 0, 0xFFFF -> commits on three consecutive cycles; expected_gc[0] ends at 0xFFFE.
- Duplicates and independence: cores 3 and 4 both stamp 10 on acc0, core5 stamp 10 on acc1 -> core3 and core5 granted in the same cycle, err_dup=1, core4 left stalled.
- Fork mid-stream: core1 pending stamp 7, exp=7, fork_valid same cycle with gc=20 -> req_ready stays 0, expected_gc becomes 20, core1 is never granted.
- Watchdog, WDOG_LIMIT=8: exp=10, core0 stamp 20 held -> err_stall=1 after 8 cycles with the macro defined; stays 0 without it.
